rx_lock: RTL and testbench
==========================

// Module: rx_lock
// PURPOSE
//  Receive-side counterpart of the UART transmit lock. Sits between the UART receiver
//  (rx_done_tick + byte) and game logic. Captures each received byte, publishes it
//  on a stable register with a one-cycle new_data strobe, and monitors link health:
//  if no byte arrives within TIMEOUT_LIMIT cycles the link is declared lost.
// PARAMETERS
//  DATA_WIDTH     8      width of received byte / data_out
//  TIMEOUT_LIMIT  57400  idle cycles in HOLD before link loss (~2 tx lock periods)
//  CNT_WIDTH      16     timeout counter width; must satisfy 2**CNT_WIDTH > TIMEOUT_LIMIT
// PORTS
//  pclk          in   1           system clock, all state on rising edge
//  rst           in   1           asynchronous reset, active-high
//  rx_done_tick  in   1           one-cycle strobe from UART rx: data_in valid this cycle
//  data_in       in   DATA_WIDTH  received byte from UART rx
//  data_out      out  DATA_WIDTH  last published byte, registered, held between updates
//  new_data      out  1           registered one-cycle pulse when data_out updates
//  link_ok       out  1           registered; 1 while bytes arrive within timeout window
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, data_out=0, new_data=0, link_ok=0,
//    counter=0, shadow=0, filter history cleared. All outputs are registers.
//  - States: IDLE (no link), CAPTURE (publish, 1 cycle), HOLD (linked, timing).
//  - IDLE: rx_done_tick=1 -> shadow<=data_in, next=CAPTURE. Else stay; counter=0.
//  - CAPTURE: data_out<=shadow, new_data<=1, link_ok<=1, counter<=0, next=HOLD.
//    rx_done_tick during CAPTURE is dropped (cannot occur at real UART rates).
//  - HOLD: counter<=counter+1 each cycle; rx_done_tick=1 -> shadow<=data_in,
//    next=CAPTURE. Else if counter==TIMEOUT_LIMIT -> next=IDLE, link_ok<=0,
//    data_out retained (last value stays valid for consumers).
//  - Simultaneous tick and timeout in HOLD: tick wins, link_ok stays 1.
//  - Latency: tick sampled at edge N -> data_out/new_data/link_ok valid after N+1;
//    new_data cleared at N+2 (exactly one cycle high per publish).
//  - Link loss: link_ok falls at edge TIMEOUT_LIMIT+1 after the CAPTURE edge
//    if no tick intervenes. Counter never exceeds TIMEOUT_LIMIT (no wrap).
//  - Illegal state encoding -> IDLE next cycle, outputs unchanged except new_data=0.
//  - Reset mid-CAPTURE/HOLD: pending shadow byte discarded, no new_data pulse.
// CONFIGURATION
//  RX_LOCK_FILTER_EN defined: repeat filter. In CAPTURE the shadow byte is
//   published only if a history byte is valid and equal to shadow; otherwise
//   history<=shadow, history marked valid, no data_out/new_data update, but
//   link_ok<=1 and counter<=0 still occur. History invalidated on reset and on
//   entry to IDLE (timeout). Rejects single corrupted bytes at one-byte latency.
//  RX_LOCK_FILTER_EN undefined: every captured byte is published; no history reg.
// TESTING
//  1. rst pulse mid-HOLD with data_out=0xA5 -> data_out=0, link_ok=0, new_data=0
//     before next pclk edge; no outputs change until next tick.
//  2. IDLE, tick with data_in=0xA5 -> after 2nd edge data_out=0xA5, link_ok=1,
//     new_data high exactly 1 cycle.
//  3. TIMEOUT_LIMIT=20, publish 0x5A, no further ticks -> link_ok=0 at edge 21
//     after CAPTURE edge, data_out stays 0x5A, state IDLE.
//  4. TIMEOUT_LIMIT=20, tick 0x3C on cycle counter==20 -> link_ok stays 1,
//     data_out=0x3C, new_data pulses once.
//  5. Tick 0x11 then tick 0x22 next cycle (during CAPTURE) -> data_out=0x11,
//     0x22 dropped, single new_data pulse.
//  6. Ticks 0x11, 0x22, 0x22 spaced 100 cycles: with RX_LOCK_FILTER_EN one
//     publish (0x22); without it three publishes, final data_out=0x22.

Source files
------------

// File: rtl/rx_lock.sv
// rx_lock: captures UART rx bytes, republishes them with a one-cycle new_data strobe and watches link health.
// Latency: tick at edge N -> data_out/new_data/link_ok at N+1. No backpressure. Optional repeat filter: RX_LOCK_FILTER_EN.
module rx_lock #(
    parameter int DATA_WIDTH    = 8,
    parameter int TIMEOUT_LIMIT = 57400,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  rx_done_tick,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  new_data,
    output logic                  link_ok
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_LIMIT);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  new_data_q, new_data_d;
    logic                  link_ok_q, link_ok_d;
    logic                  timeout;

`ifdef RX_LOCK_FILTER_EN
    logic [DATA_WIDTH-1:0] hist_q, hist_d;
    logic                  hist_vld_q, hist_vld_d;
`endif

    assign timeout = (cnt_q == LIMIT);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:    state_d = rx_done_tick ? S_CAPTURE : S_IDLE;
            S_CAPTURE: state_d = S_HOLD;
            S_HOLD: begin
                if (rx_done_tick)  state_d = S_CAPTURE;
                else if (timeout)  state_d = S_IDLE;
                else               state_d = S_HOLD;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shadow_d   = shadow_q;
        data_out_d = data_out_q;
        cnt_d      = cnt_q;
        new_data_d = 1'b0;
        link_ok_d  = link_ok_q;
`ifdef RX_LOCK_FILTER_EN
        hist_d     = hist_q;
        hist_vld_d = hist_vld_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rx_done_tick) shadow_d = data_in;
            end
            S_CAPTURE: begin
                cnt_d     = '0;
                link_ok_d = 1'b1;
`ifdef RX_LOCK_FILTER_EN
                // Publish only a byte seen twice in a row; otherwise remember it.
                if (hist_vld_q && (hist_q == shadow_q)) begin
                    data_out_d = shadow_q;
                    new_data_d = 1'b1;
                end else begin
                    hist_d     = shadow_q;
                    hist_vld_d = 1'b1;
                end
`else
                data_out_d = shadow_q;
                new_data_d = 1'b1;
`endif
            end
            S_HOLD: begin
                // Saturate so the counter never wraps past the limit.
                if (!timeout) cnt_d = cnt_q + CNT_WIDTH'(1);
                if (rx_done_tick) begin
                    shadow_d = data_in;
                end else if (timeout) begin
                    link_ok_d = 1'b0;
`ifdef RX_LOCK_FILTER_EN
                    hist_vld_d = 1'b0;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            shadow_q   <= '0;
            data_out_q <= '0;
            cnt_q      <= '0;
            new_data_q <= 1'b0;
            link_ok_q  <= 1'b0;
`ifdef RX_LOCK_FILTER_EN
            hist_q     <= '0;
            hist_vld_q <= 1'b0;
`endif
        end else begin
            shadow_q   <= shadow_d;
            data_out_q <= data_out_d;
            cnt_q      <= cnt_d;
            new_data_q <= new_data_d;
            link_ok_q  <= link_ok_d;
`ifdef RX_LOCK_FILTER_EN
            hist_q     <= hist_d;
            hist_vld_q <= hist_vld_d;
`endif
        end
    end

    assign data_out = data_out_q;
    assign new_data = new_data_q;
    assign link_ok  = link_ok_q;

endmodule

// File: tb/tb_rx_lock.sv
// Scoreboard bench for rx_lock: stimulus pushes expected outputs, a monitor pops and compares each cycle.
module tb_rx_lock;

    localparam int DW = 8;
    localparam int T  = 20;

    logic          pclk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_done_tick = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          new_data;
    logic          link_ok;

    rx_lock #(.DATA_WIDTH(DW), .TIMEOUT_LIMIT(T), .CNT_WIDTH(16)) dut (
        .pclk(pclk), .rst(rst), .rx_done_tick(rx_done_tick), .data_in(data_in),
        .data_out(data_out), .new_data(new_data), .link_ok(link_ok)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [DW-1:0] dout;
        logic          nd;
        logic          lk;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] pub_q[$];
    int            n_pass = 0;
    int            n_total = 0;

    // Reference model: an accepted tick publishes on the following edge; ticks landing on
    // that publish edge are lost; the link expires T+1 edges after the last publish edge.
    int            cyc = 0;
    int            deadline = 0;
    bit            linked, pending;
    logic [DW-1:0] pend_byte, last_pub;
`ifdef RX_LOCK_FILTER_EN
    bit            hist_vld;
    logic [DW-1:0] hist;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        linked    = 1'b0;
        pending   = 1'b0;
        pend_byte = '0;
        last_pub  = '0;
`ifdef RX_LOCK_FILTER_EN
        hist_vld  = 1'b0;
        hist      = '0;
`endif
    endtask

    task automatic model_step(input bit tick, input logic [DW-1:0] d);
        bit pub;
        bit nd;
        cyc++;
        nd = 1'b0;
        if (pending) begin
            pending  = 1'b0;
            linked   = 1'b1;
            deadline = cyc + T + 1;
            pub      = 1'b1;
`ifdef RX_LOCK_FILTER_EN
            if (!(hist_vld && hist == pend_byte)) begin
                pub      = 1'b0;
                hist     = pend_byte;
                hist_vld = 1'b1;
            end
`endif
            if (pub) begin
                last_pub = pend_byte;
                nd       = 1'b1;
                pub_q.push_back(pend_byte);
            end
        end else if (tick) begin
            pending   = 1'b1;
            pend_byte = d;
        end else if (linked && cyc == deadline) begin
            linked = 1'b0;
`ifdef RX_LOCK_FILTER_EN
            hist_vld = 1'b0;
`endif
        end
        exp_q.push_back('{dout: last_pub, nd: nd, lk: linked});
    endtask

    task automatic drive(input bit tick, input logic [DW-1:0] d);
        rx_done_tick = tick;
        data_in      = d;
        @(posedge pclk);
        model_step(tick, d);
        @(negedge pclk);
        rx_done_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, DW'($urandom));
    endtask

    task automatic reset_pulse();
        #1 rst = 1'b1;
        #1;
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_new_data", 32'(new_data), 32'h0);
        check("rst_link_ok", 32'(link_ok), 32'h0);
        @(negedge pclk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge pclk);
            if (!rst) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("data_out", 32'(data_out), 32'(e.dout));
                    check("new_data", 32'(new_data), 32'(e.nd));
                    check("link_ok", 32'(link_ok), 32'(e.lk));
                end
                if (new_data) begin
                    if (pub_q.size() == 0) begin
                        n_total++;
                        $display("FAIL publish: unexpected new_data with data_out=0x%0h, expected none at %0t",
                                 data_out, $time);
                    end else begin
                        check("publish_byte", 32'(data_out), 32'(pub_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int pct;
        logic [DW-1:0] b;
        model_reset();
        #2;
        check("init_data_out", 32'(data_out), 32'h0);
        check("init_new_data", 32'(new_data), 32'h0);
        check("init_link_ok", 32'(link_ok), 32'h0);
        @(negedge pclk);
        #1 rst = 1'b0;

        // publish from IDLE, then reset in HOLD
        drive(1'b1, 8'hA5); idle(5);
        reset_pulse(); idle(3);
        // timeout with no further ticks
        drive(1'b1, 8'h5A); idle(T + 10);
        // tick exactly on the timeout cycle
        drive(1'b1, 8'h3C); idle(1); idle(T); drive(1'b1, 8'h3C); idle(5);
        // tick during publish cycle is dropped
        drive(1'b1, 8'h11); drive(1'b1, 8'h22); idle(5);
        // repeat-filter pattern
        drive(1'b1, 8'h11); idle(9); drive(1'b1, 8'h22); idle(9); drive(1'b1, 8'h22); idle(9);
        // reset with a byte pending publish
        drive(1'b1, 8'h77); reset_pulse(); idle(3);

        for (int i = 0; i < 1500; i++) begin
            if (i % 150 == 0) pct = (i / 150) % 3 == 0 ? 3 : ((i / 150) % 3 == 1 ? 12 : 50);
            b = ($urandom_range(0, 3) != 0) ? (($urandom_range(0, 1) != 0) ? 8'h22 : 8'h44) : DW'($urandom);
            drive($urandom_range(0, 99) < pct, b);
        end
        idle(2);
        #1;
        check("exp_queue_drained", 32'(exp_q.size()), 32'h0);
        check("pub_queue_drained", 32'(pub_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
